// File: rtl/caliptra_prim_esc_receiver.sv
// Escalation receiver: decodes the differential escalation pair, answers pings and
// escalations on the response pair, and raises esc_req_o on escalation, integrity failure or ping timeout.
//
// state     | meaning
// Idle      | waiting for ping or escalation, ping-timeout counter running
// Check     | first asserted cycle seen, ping or escalation not yet known
// PingResp  | ping confirmed, finishing the response pattern
// EscResp   | escalation in progress, response toggles each cycle
// SigInt    | differential input broken, response driven non-complementary
module caliptra_prim_esc_receiver #(
  parameter int unsigned TimeoutCntDw = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] esc_tx_i,
  output logic [1:0] esc_rx_o,
  output logic       esc_req_o
);

  typedef enum logic [2:0] {
    Idle,
    Check,
    PingResp,
    EscResp,
    SigInt
  } state_e;

  state_e                  state_q, state_d;
  logic                    resp_p_q, resp_p_d;
  logic                    resp_n_q, resp_n_d;
  logic                    esc_req_q;
  logic                    timeout_q, timeout_d;
  logic [TimeoutCntDw-1:0] cnt_q;

  logic esc_p, esc_n, esc_en, sig_int, cnt_max;

  assign esc_p   = esc_tx_i[1];
  assign esc_n   = esc_tx_i[0];
  assign esc_en  = esc_p & ~esc_n;
  assign sig_int = (esc_p == esc_n);
  assign cnt_max = &cnt_q;

  assign timeout_d = timeout_q | ((state_q == Idle) & cnt_max);

  always_comb begin
    state_d  = state_q;
    resp_p_d = resp_p_q;
    resp_n_d = resp_n_q;
    if (sig_int) begin
      state_d = SigInt;
      // Entering SigInt starts the non-complementary pattern at 1/1, then toggles.
      if (state_q == SigInt) begin
        resp_p_d = ~resp_p_q;
        resp_n_d = ~resp_p_q;
      end else begin
        resp_p_d = 1'b1;
        resp_n_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        Idle: begin
          state_d  = esc_en ? Check : Idle;
          resp_p_d = esc_en;
        end
        Check: begin
          state_d  = esc_en ? EscResp : PingResp;
          resp_p_d = 1'b0;
        end
        PingResp: begin
          state_d  = esc_en ? EscResp : Idle;
          resp_p_d = 1'b1;
        end
        EscResp: begin
          state_d  = esc_en ? EscResp : Idle;
          resp_p_d = esc_en ? ~resp_p_q : 1'b0;
        end
        SigInt: begin
          state_d  = Idle;
          resp_p_d = 1'b0;
        end
        default: begin
          state_d  = Idle;
          resp_p_d = 1'b0;
        end
      endcase
      resp_n_d = ~resp_p_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      resp_p_q  <= 1'b0;
      resp_n_q  <= 1'b1;
      esc_req_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      resp_p_q  <= resp_p_d;
      resp_n_q  <= resp_n_d;
      timeout_q <= timeout_d;
      esc_req_q <= (state_d == EscResp) | (state_d == SigInt) | timeout_d;
      // Counter only moves in Idle; outside Idle it already holds zero.
      if (state_q == Idle) begin
        if (esc_en || sig_int) begin
          cnt_q <= '0;
        end else if (!cnt_max) begin
          cnt_q <= cnt_q + TimeoutCntDw'(1);
        end
      end
    end
  end

  assign esc_rx_o  = {resp_p_q, resp_n_q};
  assign esc_req_o = esc_req_q;

endmodule

// File: tb/tb_caliptra_prim_esc_receiver.sv
// Self-checking bench for caliptra_prim_esc_receiver: directed scenarios with fixed
// expectations plus a randomized run against a behavioural model.
module tb_caliptra_prim_esc_receiver;

  localparam int TW = 4;
  localparam int CNT_MAX = (1 << TW) - 1;
  localparam logic [1:0] TX_IDLE = 2'b01;
  localparam logic [1:0] TX_ESC  = 2'b10;

  logic       clk;
  logic       rst_n;
  logic [1:0] esc_tx;
  logic [1:0] esc_rx;
  logic       esc_req;

  int checks = 0;
  int errors = 0;

  // behavioural model: mode 0 idle, 1 first-assert, 2 ping answer, 3 escalating, 4 broken pair
  int   m_mode;
  logic m_rp, m_rn, m_req, m_to;
  int   m_idle_run;

  caliptra_prim_esc_receiver #(.TimeoutCntDw(TW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .esc_tx_i (esc_tx),
    .esc_rx_o (esc_rx),
    .esc_req_o(esc_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic [1:0] tx, input logic rst);
    logic asserted, broken, fire;
    if (!rst) begin
      m_mode = 0; m_rp = 1'b0; m_rn = 1'b1; m_req = 1'b0; m_to = 1'b0; m_idle_run = 0;
      return;
    end
    asserted = tx[1] & ~tx[0];
    broken   = (tx[1] == tx[0]);
    fire     = (m_mode == 0) && (m_idle_run == CNT_MAX);
    if (m_mode == 0) begin
      if (asserted || broken) m_idle_run = 0;
      else if (m_idle_run < CNT_MAX) m_idle_run++;
    end
    if (fire) m_to = 1'b1;
    if (broken) begin
      m_rp = (m_mode == 4) ? ~m_rp : 1'b1;
      m_rn = m_rp;
      m_mode = 4;
    end else begin
      if (m_mode == 0) begin
        m_rp = asserted;
        m_mode = asserted ? 1 : 0;
      end else if (m_mode == 1) begin
        m_rp = 1'b0;
        m_mode = asserted ? 3 : 2;
      end else if (m_mode == 2) begin
        m_rp = 1'b1;
        m_mode = asserted ? 3 : 0;
      end else if (m_mode == 3) begin
        m_rp = asserted ? ~m_rp : 1'b0;
        m_mode = asserted ? 3 : 0;
      end else begin
        m_rp = 1'b0;
        m_mode = 0;
      end
      m_rn = ~m_rp;
    end
    m_req = (m_mode == 3) || (m_mode == 4) || m_to;
  endtask

  // called at a negedge: apply inputs, take one rising edge, return at the next negedge
  task automatic drive(input logic [1:0] tx, input logic rst);
    esc_tx = tx;
    rst_n  = rst;
    @(posedge clk);
    model_step(tx, rst);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(TX_IDLE, 1'b0);
    drive(TX_IDLE, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (esc_rx !== 2'b01) begin
      errors++; $display("FAIL reset_rx: got %b want 01", esc_rx);
    end
    checks++;
    if (esc_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b want 0", esc_req);
    end
  endtask

  task automatic test_ping();
    logic exp_rp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? TX_ESC : TX_IDLE, 1'b1);
      checks++;
      if (esc_rx !== {exp_rp[k], ~exp_rp[k]} || esc_req !== 1'b0) begin
        errors++;
        $display("FAIL ping[%0d]: got rx=%b req=%b want rx=%b req=0", k, esc_rx, esc_req, {exp_rp[k], ~exp_rp[k]});
      end
    end
  endtask

  task automatic test_escalation();
    logic exp_rp  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_req [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive((k < 5) ? TX_ESC : TX_IDLE, 1'b1);
      checks++;
      if (esc_rx !== {exp_rp[k], ~exp_rp[k]} || esc_req !== exp_req[k]) begin
        errors++;
        $display("FAIL esc[%0d]: got rx=%b req=%b want rx=%b req=%b", k, esc_rx, esc_req, {exp_rp[k], ~exp_rp[k]}, exp_req[k]);
      end
    end
  endtask

  task automatic test_sig_int(input logic lvl);
    logic exp_r [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive({lvl, lvl}, 1'b1);
      checks++;
      if (esc_rx !== {exp_r[k], exp_r[k]} || esc_req !== 1'b1) begin
        errors++;
        $display("FAIL sigint%0d[%0d]: got rx=%b req=%b want rx=%b req=1", lvl, k, esc_rx, esc_req, {exp_r[k], exp_r[k]});
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(TX_IDLE, 1'b1);
      checks++;
      if (esc_rx !== 2'b01 || esc_req !== 1'b0) begin
        errors++;
        $display("FAIL sigint%0d_restore[%0d]: got rx=%b req=%b want rx=01 req=0", lvl, k, esc_rx, esc_req);
      end
    end
  endtask

  task automatic test_timeout();
    logic exp_rp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int k = 1; k <= 20; k++) begin
        drive(TX_IDLE, 1'b1);
        checks++;
        if (esc_req !== (k >= 16) || esc_rx !== 2'b01) begin
          errors++;
          $display("FAIL timeout%0d[%0d]: got req=%b rx=%b want req=%b rx=01", pass, k, esc_req, esc_rx, (k >= 16));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? TX_ESC : TX_IDLE, 1'b1);
      checks++;
      if (esc_req !== 1'b1 || esc_rx !== {exp_rp[k], ~exp_rp[k]}) begin
        errors++;
        $display("FAIL timeout_sticky[%0d]: got req=%b rx=%b want req=1 rx=%b", k, esc_req, esc_rx, {exp_rp[k], ~exp_rp[k]});
      end
    end
    do_reset();
    for (int k = 0; k < 200; k++) begin
      drive((k % 10 == 0) ? TX_ESC : TX_IDLE, 1'b1);
      checks++;
      if (esc_req !== 1'b0) begin
        errors++;
        $display("FAIL ping_keepalive[%0d]: got req=%b want 0", k, esc_req);
      end
    end
  endtask

  task automatic test_reset_mid_esc();
    logic [1:0] exp_rx  [6] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    logic       exp_req [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive((k < 5) ? TX_ESC : TX_IDLE, (k != 2));
      checks++;
      if (esc_rx !== exp_rx[k] || esc_req !== exp_req[k]) begin
        errors++;
        $display("FAIL rst_mid_esc[%0d]: got rx=%b req=%b want rx=%b req=%b", k, esc_rx, esc_req, exp_rx[k], exp_req[k]);
      end
    end
  endtask

  task automatic test_ping_then_esc();
    logic [1:0] seq     [6] = '{TX_ESC, TX_IDLE, TX_ESC, TX_ESC, TX_ESC, TX_IDLE};
    logic       exp_rp  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_req [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(seq[k], 1'b1);
      checks++;
      if (esc_rx !== {exp_rp[k], ~exp_rp[k]} || esc_req !== exp_req[k]) begin
        errors++;
        $display("FAIL ping_then_esc[%0d]: got rx=%b req=%b want rx=%b req=%b", k, esc_rx, esc_req, {exp_rp[k], ~exp_rp[k]}, exp_req[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] tx;
    logic       rst;
    int         run, sel;
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      sel = $urandom_range(0, 99);
      run = $urandom_range(1, 4);
      if (sel < 40) tx = TX_IDLE;
      else if (sel < 75) tx = TX_ESC;
      else if (sel < 85) tx = 2'b11;
      else if (sel < 93) tx = 2'b00;
      else begin
        tx = TX_IDLE; run = $urandom_range(14, 20);
      end
      for (int k = 0; k < run; k++) begin
        rst = ($urandom_range(0, 99) >= 2);
        drive(tx, rst);
        checks++;
        if (esc_rx !== {m_rp, m_rn} || esc_req !== m_req) begin
          errors++;
          $display("FAIL random[%0d.%0d]: tx=%b rst=%b got rx=%b req=%b want rx=%b req=%b", seg, k, tx, rst, esc_rx, esc_req, {m_rp, m_rn}, m_req);
        end
      end
    end
  endtask

  initial begin
    esc_tx = TX_IDLE;
    rst_n  = 1'b0;
    @(negedge clk);
    test_reset();
    test_ping();
    test_escalation();
    test_sig_int(1'b1);
    test_sig_int(1'b0);
    test_timeout();
    test_reset_mid_esc();
    test_ping_then_esc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/caliptra_prim_esc_receiver.md
# caliptra_prim_esc_receiver

Escalation receiver: the stage directly downstream of an escalation sender. It decodes the differential escalation pair (`esc_p`/`esc_n`), answers pings and escalations on the differential response pair (`resp_p`/`resp_n`), and reports integrity errors back to the sender. It raises `esc_req_o` toward the local reaction logic on a genuine escalation, a signal-integrity failure, or a ping timeout. It sits at the consumer end of each escalation channel, on the same clock as the sender.

## Interface
- `TimeoutCntDw`, default 16: width of the ping-timeout counter. Timeout fires after 2^TimeoutCntDw − 1 consecutive IDLE cycles.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `esc_tx_i`  in  esc_tx_t (2)  differential escalation/ping input {esc_p, esc_n}.
- `esc_rx_o`  out  esc_rx_t (2)  differential response {resp_p, resp_n}, registered.
- `esc_req_o`  out  1  escalation request to local logic, registered.

## Operation
- Input decode on each sampled cycle. No input synchronizer is used, because the input is on the same clock as the sender.
  - `e` = esc_p & ~esc_n (valid assert).
  - `i` = (esc_p == esc_n) (integrity fail).
  - Otherwise the input is deasserted.
- FSM states: IDLE, CHECK, PING_RESP, ESC_RESP, SIG_INT. `i` has priority over `e` in every state.
  - **IDLE:**
    - `i` → SIG_INT.
    - `e` → CHECK, resp_p←1.
    - else stay, resp_p←0.
  - **CHECK:**
    - `i` → SIG_INT.
    - `e` → ESC_RESP, resp_p←0.
    - else → PING_RESP, resp_p←0.
  - **PING_RESP:**
    - `i` → SIG_INT.
    - `e` → ESC_RESP, resp_p←1.
    - else → IDLE, resp_p←1.
  - **ESC_RESP:**
    - `i` → SIG_INT.
    - `e` → stay, resp_p←~resp_p (toggle every cycle).
    - else → IDLE, resp_p←0.
  - **SIG_INT:**
    - `i` → stay; resp_p and resp_n are both driven to the same value and toggle each cycle (1,0,1,…), so the sender detects the integrity failure.
    - else → IDLE, resp_p←0, resp_n←1.
- resp_n = ~resp_p in all states except SIG_INT.
- esc_req_o is registered. Its next value is 1 when the next state is ESC_RESP or SIG_INT, or when timeout_q = 1.
- Ping-timeout counter (TimeoutCntDw bits, reset 0):
  - Increments each cycle the FSM is in IDLE and no transition occurs.
  - Clears to 0 on any transition out of IDLE.
  - Saturates at all-ones; it does not wrap.
  - When it equals all-ones while in IDLE, timeout_q is set on the next edge. timeout_q is sticky until reset.
  - While timeout_q = 1, esc_req_o = 1; the FSM and response path continue to operate normally.
- Reset values: state IDLE, resp_p=0, resp_n=1 (ESC_RX_DEFAULT), esc_req_o=0, counter 0, timeout_q=0.

## Timing
- Let t0 be the first edge sampling `e`.
  - resp_p=1 after t0.
  - Ping (1-cycle pulse): resp_p sequence after t0, t0+1, t0+2, t0+3 is 1, 0, 1, 0. esc_req_o stays 0.
  - Escalation (`e` held for N ≥ 2 sampled cycles):
    - esc_req_o rises after t0+1 and falls after edge t0+N, the first edge sampling deassert. High for exactly N−1 cycles.
    - resp_p after t0, t0+1, … is 1, 0, 1, 0, … toggling through the escalation.
  - 2-cycle pulse: treated as an escalation with N=2, so esc_req_o is high for 1 cycle.
- Integrity fail:
  - esc_req_o=1 and resp_p=resp_n=1 after the first edge sampling `i`.
  - Both clear after the first edge sampling a valid, deasserted input.
- Timeout fires when `e` and `i` are never sampled for 2^TimeoutCntDw − 1 consecutive cycles from reset or from the last return to IDLE. timeout_q is set on the following edge, and esc_req_o is high from that same edge.
- Reset mid-operation: when rst_ni is sampled low, all outputs take reset values after that edge, regardless of state. timeout_q is cleared.

## Test plan
- **Ping.** After reset, drive esc_p=1/esc_n=0 for 1 cycle, then hold idle (0/1).
  - Required: resp_p 1,0,1,0; resp_n its complement; esc_req_o stays 0.
- **Escalation.** Hold esc_p=1/esc_n=0 for 5 cycles, then deassert.
  - Required: esc_req_o high for exactly 4 cycles, starting the cycle after the second sampled assert.
  - Required: resp_p toggles 1,0,1,0,1 then returns to 0; resp_n is the complement throughout.
- **Signal integrity.** Drive esc_p=esc_n=1 for 4 cycles from IDLE, then restore 0/1.
  - Required: resp_p==resp_n, toggling 1,0,1,0; esc_req_o=1 for 4 cycles.
  - Required: after restore, esc_rx_o returns to 0/1 and esc_req_o returns to 0.
  - Repeat with esc_p=esc_n=0 and the same expectations.
- **Timeout.** With TimeoutCntDw=4, hold the input idle after reset.
  - Required: esc_req_o=0 through cycle 15, 1 from cycle 16 onward, and it stays 1 after a subsequent ping.
  - Also required: a 1-cycle ping every 10 cycles keeps esc_req_o=0 for 200 cycles.
- **Reset mid-escalation.** Assert rst_ni=0 for 1 cycle during the 3rd cycle of an escalation, with `e` still held.
  - Required: after that edge, esc_rx_o=0/1, esc_req_o=0, and the counter is 0.
  - Required: with `e` still held, the FSM re-enters CHECK and esc_req_o re-asserts 2 edges after reset release.
- **Ping then escalation.** Drive a 1-cycle ping, then assert `e` again while in PING_RESP and hold for 3 cycles.
  - Required: esc_req_o asserts after the PING_RESP edge and stays high for 3 cycles.
  - Required: resp_p continues toggling 1,0,1.
